// File: rtl/iommu_err_responder_pkg.sv
// Shared AXI/IOMMU channel types and the IOMMU config defaults for the error responder.
// Fault path and responder both pull the error response code and data pattern from here.
package axi_pkg;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
endpackage

package lint_wrapper;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned SidWidth  = 24;
    localparam int unsigned SsidWidth = 20;

    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef logic [SidWidth-1:0]    sid_t;
    typedef logic [SsidWidth-1:0]   ssid_t;

    typedef struct packed {
        id_t         id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic        user;
        sid_t        stream_id;
        logic        ss_id_valid;
        ssid_t       substream_id;
    } ax_chan_iommu_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        logic  user;
    } w_chan_t;

    typedef struct packed {
        id_t         id;
        logic [1:0]  resp;
        logic        user;
    } b_chan_t;

    typedef struct packed {
        id_t         id;
        data_t       data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_iommu_t aw;
        logic           aw_valid;
        w_chan_t        w;
        logic           w_valid;
        logic           b_ready;
        ax_chan_iommu_t ar;
        logic           ar_valid;
        logic           r_ready;
    } req_iommu_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

package iommu_err_responder_pkg;
    localparam axi_pkg::resp_t     ERR_RESP      = axi_pkg::RESP_SLVERR;
    localparam lint_wrapper::data_t ERR_RESP_DATA = 64'hBADC_AB1E_BADC_AB1E;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
endpackage

// File: rtl/iommu_err_fault_log.sv
// Captures stream/substream identity of each aborted AW/AR and counts aborts (saturating).
// Latency: pulse and fields one cycle after the handshake; never backpressures.
// Strobes are mutually exclusive by construction upstream; AW wins if both ever assert.
module iommu_err_fault_log
    import lint_wrapper::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_hs_i,
    input  logic                ar_hs_i,
    input  sid_t                aw_sid_i,
    input  logic                aw_ssidv_i,
    input  ssid_t               aw_ssid_i,
    input  sid_t                ar_sid_i,
    input  logic                ar_ssidv_i,
    input  ssid_t               ar_ssid_i,
    output logic                fault_valid_o,
    output logic                fault_is_read_o,
    output sid_t                fault_sid_o,
    output logic                fault_ssidv_o,
    output ssid_t               fault_ssid_o,
    output logic [CntWidth-1:0] fault_cnt_o
);
    logic                valid_d, valid_q;
    logic                is_read_d, is_read_q;
    sid_t                sid_d, sid_q;
    logic                ssidv_d, ssidv_q;
    ssid_t               ssid_d, ssid_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        valid_d   = aw_hs_i | ar_hs_i;
        is_read_d = is_read_q;
        sid_d     = sid_q;
        ssidv_d   = ssidv_q;
        ssid_d    = ssid_q;
        cnt_d     = cnt_q;
        if (aw_hs_i) begin
            is_read_d = 1'b0;
            sid_d     = aw_sid_i;
            ssidv_d   = aw_ssidv_i;
            ssid_d    = aw_ssid_i;
        end else if (ar_hs_i) begin
            is_read_d = 1'b1;
            sid_d     = ar_sid_i;
            ssidv_d   = ar_ssidv_i;
            ssid_d    = ar_ssid_i;
        end
        if (valid_d && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            is_read_q <= 1'b0;
            sid_q     <= '0;
            ssidv_q   <= 1'b0;
            ssid_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            is_read_q <= is_read_d;
            sid_q     <= sid_d;
            ssidv_q   <= ssidv_d;
            ssid_q    <= ssid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fault_valid_o   = valid_q;
    assign fault_is_read_o = is_read_q;
    assign fault_sid_o     = sid_q;
    assign fault_ssidv_o   = ssidv_q;
    assign fault_ssid_o    = ssid_q;
    assign fault_cnt_o     = cnt_q;
endmodule

// File: rtl/iommu_err_responder.sv
// AXI4 slave terminating IOMMU-faulted transactions with error B/R responses of correct length.
// Latency: W drain from AW+1, B at last-W+1, first R at AR+1, len+1 R beats back to back.
// Backpressure: B and R hold stable until ready; W stalled until its AW is taken.
module iommu_err_responder
    import lint_wrapper::*;
    import iommu_err_responder_pkg::*;
#(
    parameter axi_pkg::resp_t Resp     = ERR_RESP,
    parameter data_t          RespData = ERR_RESP_DATA,
    parameter int unsigned    CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  req_iommu_t          req_i,
    output resp_t               resp_o,
    output logic                fault_valid_o,
    output logic                fault_is_read_o,
    output logic [23:0]         fault_sid_o,
    output logic                fault_ssidv_o,
    output logic [19:0]         fault_ssid_o,
    output logic [CntWidth-1:0] fault_cnt_o
);
    w_state_e   w_state_q;
    r_state_e   r_state_q;
    id_t        b_id_q;
    id_t        r_id_q;
    logic [7:0] r_cnt_q;
    logic       aw_hs;
    logic       ar_hs;
    logic       ar_ready;

    // AR yields to a same-cycle AW so the fault log never sees two events at once.
    assign aw_hs    = req_i.aw_valid && (w_state_q == W_IDLE);
    assign ar_ready = (r_state_q == R_IDLE) && !aw_hs;
    assign ar_hs    = req_i.ar_valid && ar_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_hs) begin
                    b_id_q    <= req_i.aw.id;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (req_i.w_valid && req_i.w.last) w_state_q <= W_RESP;
                W_RESP: if (req_i.b_ready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_cnt_q   <= 8'd0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    r_id_q    <= req_i.ar.id;
                    r_cnt_q   <= req_i.ar.len;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (req_i.r_ready) begin
                    if (r_cnt_q == 8'd0) r_state_q <= R_IDLE;
                    else                 r_cnt_q   <= r_cnt_q - 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = (w_state_q == W_IDLE);
        resp_o.w_ready  = (w_state_q == W_DATA);
        resp_o.b_valid  = (w_state_q == W_RESP);
        resp_o.b.id     = b_id_q;
        resp_o.b.resp   = Resp;
        resp_o.ar_ready = ar_ready;
        resp_o.r_valid  = (r_state_q == R_DATA);
        resp_o.r.id     = r_id_q;
        resp_o.r.data   = RespData;
        resp_o.r.resp   = Resp;
        resp_o.r.last   = (r_cnt_q == 8'd0);
    end

    // Address, attributes and write payload are irrelevant to an abort.
    logic unused_req;
    assign unused_req = ^req_i;

    iommu_err_fault_log #(
        .CntWidth (CntWidth)
    ) u_fault_log (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .aw_hs_i         (aw_hs),
        .ar_hs_i         (ar_hs),
        .aw_sid_i        (req_i.aw.stream_id),
        .aw_ssidv_i      (req_i.aw.ss_id_valid),
        .aw_ssid_i       (req_i.aw.substream_id),
        .ar_sid_i        (req_i.ar.stream_id),
        .ar_ssidv_i      (req_i.ar.ss_id_valid),
        .ar_ssid_i       (req_i.ar.substream_id),
        .fault_valid_o   (fault_valid_o),
        .fault_is_read_o (fault_is_read_o),
        .fault_sid_o     (fault_sid_o),
        .fault_ssidv_o   (fault_ssidv_o),
        .fault_ssid_o    (fault_ssid_o),
        .fault_cnt_o     (fault_cnt_o)
    );
endmodule

// File: tb/tb_iommu_err_responder.sv
// Directed + randomized bench for iommu_err_responder with a transaction-level reference model.
module tb_iommu_err_responder;
    import lint_wrapper::*;

    localparam logic [1:0]  SLVERR   = 2'b10;
    localparam logic [63:0] ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;
    localparam int          CW       = 3;
    localparam int          CNT_MAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    req_iommu_t    req;
    resp_t         resp;
    logic          fault_valid, fault_is_read, fault_ssidv;
    logic [23:0]   fault_sid;
    logic [19:0]   fault_ssid;
    logic [CW-1:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    iommu_err_responder #(
        .CntWidth (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_i           (req),
        .resp_o          (resp),
        .fault_valid_o   (fault_valid),
        .fault_is_read_o (fault_is_read),
        .fault_sid_o     (fault_sid),
        .fault_ssidv_o   (fault_ssidv),
        .fault_ssid_o    (fault_ssid),
        .fault_cnt_o     (fault_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ax_chan_iommu_t mk_ax(input id_t id, input logic [7:0] len,
                                             input sid_t sid, input logic ssidv, input ssid_t ssid);
        ax_chan_iommu_t ax;
        ax              = '0;
        ax.id           = id;
        ax.addr         = {$urandom, $urandom};
        ax.len          = len;
        ax.size         = 3'd3;
        ax.burst        = 2'b01;
        ax.stream_id    = sid;
        ax.ss_id_valid  = ssidv;
        ax.substream_id = ssid;
        return ax;
    endfunction

    // Model: every accepted AW/AR is one abort; the count sticks at its maximum.
    task automatic log_check(input logic is_read, input sid_t sid, input logic ssidv, input ssid_t ssid);
        if (exp_cnt < CNT_MAX) exp_cnt++;
        check("flt_vld", fault_valid, 1);
        check("flt_is_read", fault_is_read, is_read);
        check("flt_sid", fault_sid, sid);
        check("flt_ssidv", fault_ssidv, ssidv);
        check("flt_ssid", fault_ssid, ssid);
        check("flt_cnt", fault_cnt, exp_cnt);
    endtask

    task automatic drain_write(input id_t id, input int nbeats, input int bstall);
        for (int i = 0; i < nbeats; i++) begin
            req.w_valid   = 1'b1;
            req.w.last    = (i == nbeats - 1);
            req.w.data    = {$urandom, $urandom};
            #1;
            check("w_rdy", resp.w_ready, 1);
            check("b_vld_early", resp.b_valid, 0);
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        #1;
        check("b_vld", resp.b_valid, 1);
        check("b_id", resp.b.id, id);
        check("b_resp", resp.b.resp, SLVERR);
        check("w_rdy_after_last", resp.w_ready, 0);
        check("flt_pulse_w", fault_valid, 0);
        for (int i = 0; i < bstall; i++) begin
            tick();
            check("b_vld_hold", resp.b_valid, 1);
            check("b_id_hold", resp.b.id, id);
        end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        #1;
        check("b_vld_clr", resp.b_valid, 0);
        check("aw_rdy_back", resp.aw_ready, 1);
    endtask

    task automatic do_write(input id_t id, input logic [7:0] len, input sid_t sid, input logic ssidv,
                            input ssid_t ssid, input int nbeats, input int prew, input int bstall);
        req.b_ready = 1'b0;
        for (int i = 0; i < prew; i++) begin
            req.w_valid = 1'b1;
            req.w.last  = (nbeats == 1);
            #1;
            check("w_rdy_pre_aw", resp.w_ready, 0);
            tick();
        end
        req.aw       = mk_ax(id, len, sid, ssidv, ssid);
        req.aw_valid = 1'b1;
        #1;
        check("aw_rdy", resp.aw_ready, 1);
        check("w_rdy_aw_cycle", resp.w_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        #1;
        log_check(1'b0, sid, ssidv, ssid);
        drain_write(id, nbeats, bstall);
    endtask

    task automatic drain_read(input id_t id, input int len, input logic bp);
        int beats;
        int cyc;
        beats = 0;
        cyc   = 0;
        while (beats <= len && cyc < 4 * len + 40) begin
            req.r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("r_vld", resp.r_valid, 1);
            check("r_id", resp.r.id, id);
            check("r_data", resp.r.data, ERR_DATA);
            check("r_resp", resp.r.resp, SLVERR);
            check("r_last", resp.r.last, (beats == len));
            check("ar_rdy_busy", resp.ar_ready, 0);
            if (cyc > 0) check("flt_pulse_r", fault_valid, 0);
            tick();
            if (req.r_ready) beats++;
            cyc++;
        end
        check("r_beats", beats, len + 1);
        req.r_ready = 1'b0;
        #1;
        check("r_vld_clr", resp.r_valid, 0);
        check("ar_rdy_back", resp.ar_ready, 1);
    endtask

    task automatic do_read(input id_t id, input logic [7:0] len, input sid_t sid, input logic ssidv,
                           input ssid_t ssid, input logic bp);
        req.ar       = mk_ax(id, len, sid, ssidv, ssid);
        req.ar_valid = 1'b1;
        #1;
        check("ar_rdy", resp.ar_ready, 1);
        tick();
        req.ar_valid = 1'b0;
        #1;
        log_check(1'b1, sid, ssidv, ssid);
        drain_read(id, int'(len), bp);
    endtask

    initial begin
        id_t        aid, bid;
        sid_t       sa, sb;
        ssid_t      qa, qb;
        logic       va, vb;
        logic [7:0] lb;

        req = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_b_vld", resp.b_valid, 0);
        check("rst_r_vld", resp.r_valid, 0);
        check("rst_w_rdy", resp.w_ready, 0);
        check("rst_flt_vld", fault_valid, 0);
        check("rst_flt_cnt", fault_cnt, 0);
        check("rst_flt_sid", fault_sid, 0);
        check("rst_flt_is_read", fault_is_read, 0);
        rst_ni = 1'b1;
        tick();
        check("post_rst_aw_rdy", resp.aw_ready, 1);
        check("post_rst_ar_rdy", resp.ar_ready, 1);

        do_write(4'd3, 8'd3, 24'h001234, 1'b1, 20'h00ABC, 4, 0, 0);
        do_read(4'd5, 8'd7, sid_t'($urandom), 1'b0, ssid_t'($urandom), 1'b0);
        do_read(id_t'($urandom), 8'd255, sid_t'($urandom), 1'b1, ssid_t'($urandom), 1'b1);

        // AW and AR offered together: AW first, AR one cycle later.
        aid = id_t'($urandom); bid = id_t'($urandom);
        sa = sid_t'($urandom); sb = sid_t'($urandom);
        qa = ssid_t'($urandom); qb = ssid_t'($urandom);
        va = 1'($urandom); vb = 1'($urandom);
        lb = 8'($urandom_range(0, 7));
        req.aw = mk_ax(aid, 8'd1, sa, va, qa);
        req.ar = mk_ax(bid, lb, sb, vb, qb);
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1;
        check("sim_aw_rdy", resp.aw_ready, 1);
        check("sim_ar_blocked", resp.ar_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        #1;
        check("sim_ar_rdy_next", resp.ar_ready, 1);
        check("sim_w_rdy", resp.w_ready, 1);
        log_check(1'b0, sa, va, qa);
        tick();
        req.ar_valid = 1'b0;
        #1;
        log_check(1'b1, sb, vb, qb);
        drain_read(bid, int'(lb), 1'b1);
        drain_write(aid, 2, 0);

        do_write(id_t'($urandom), 8'd0, sid_t'($urandom), 1'b0, ssid_t'($urandom), 1, 3, 5);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(id_t'($urandom), 8'($urandom_range(0, 15)), sid_t'($urandom), 1'($urandom),
                         ssid_t'($urandom), $urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                do_read(id_t'($urandom), 8'($urandom_range(0, 15)), sid_t'($urandom), 1'($urandom),
                        ssid_t'($urandom), 1'b1);
        end

        // Reset while beat 3 of an 8-beat read is on the bus.
        aid = id_t'($urandom);
        sa  = sid_t'($urandom);
        req.ar = mk_ax(aid, 8'd7, sa, 1'b0, 20'h0);
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        #1;
        log_check(1'b1, sa, 1'b0, 20'h0);
        req.r_ready = 1'b1;
        tick();
        tick();
        #1;
        check("mid_r_vld", resp.r_valid, 1);
        check("mid_r_last", resp.r.last, 0);
        rst_ni = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_r_vld", resp.r_valid, 0);
        check("mid_rst_flt_cnt", fault_cnt, exp_cnt);
        check("mid_rst_flt_vld", fault_valid, 0);
        req.r_ready = 1'b0;
        tick();
        rst_ni = 1'b1;
        do_read(id_t'($urandom), 8'($urandom_range(0, 7)), sid_t'($urandom), 1'b1, ssid_t'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
